adder_carry_seq: RTL and testbench

Multi-precision sequential adder for operands of N*W bits. Operands arrive one N-bit word per accepted cycle, least-significant word first. The carry is registered between words, so the block chains the N-bit add-with-carry-out across W words. It sits downstream of the team's N-bit carry-out adder stage and reuses that arithmetic (sum plus carry-out) per word. It streams sum words out and reports the final carry.

---
 rtl/adder_carry_seq.sv | 97 +++++++++
 tb/tb_adder_carry_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_carry_seq.sv
// Multi-precision sequential adder: adds two N*W-bit operands one N-bit word
// per accepted cycle (LSW first), chaining the carry between words.
module adder_carry_seq #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] sum_out,
  output logic         sum_valid,
  output logic         last,
  output logic         cout,
  output logic         done_tick
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    sum_d;
  logic            sum_valid_d, last_d, cout_d, done_d;
  logic [N:0]      ext;

  // Word-level add with carry-in from the previous word
  assign ext = {1'b0, a_in} + {1'b0, b_in} + {{N{1'b0}}, carry_q};

  assign in_ready = (state_q == RUN);

  // Next-state and next-output decode
  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    sum_d       = sum_out;
    sum_valid_d = 1'b0;
    last_d      = 1'b0;
    done_d      = 1'b0;
    cout_d      = cout;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          carry_d = 1'b0;
          cnt_d   = '0;
          cout_d  = 1'b0;
        end
      end
      RUN: begin
        if (in_valid) begin
          sum_d       = ext[N-1:0];
          sum_valid_d = 1'b1;
          carry_d     = ext[N];
          if (cnt_q == CW'(W - 1)) begin
            last_d  = 1'b1;
            done_d  = 1'b1;
            cout_d  = ext[N];
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
      last      <= 1'b0;
      cout      <= 1'b0;
      done_tick <= 1'b0;
    end else begin
      state_q   <= state_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      sum_out   <= sum_d;
      sum_valid <= sum_valid_d;
      last      <= last_d;
      cout      <= cout_d;
      done_tick <= done_d;
    end
  end

endmodule

// File: tb/tb_adder_carry_seq.sv
// Self-checking bench for adder_carry_seq: expected words and carry come from
// a whole-operand integer add, then sliced into N-bit words.
module tb_adder_carry_seq;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 4;
  localparam int unsigned NW = N * W;

  logic         clk, reset;
  logic         start, in_valid, in_ready, sum_valid, last, cout, done_tick;
  logic [N-1:0] a_in, b_in, sum_out;

  logic         w1_start, w1_valid, w1_ready, w1_sv, w1_last, w1_cout, w1_done;
  logic [N-1:0] w1_a, w1_b, w1_sum;

  int checks = 0;
  int errors = 0;

  adder_carry_seq #(.N(N), .W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
    .in_valid(in_valid), .in_ready(in_ready), .sum_out(sum_out),
    .sum_valid(sum_valid), .last(last), .cout(cout), .done_tick(done_tick)
  );

  adder_carry_seq #(.N(N), .W(1)) dut_w1 (
    .clk(clk), .reset(reset), .start(w1_start), .a_in(w1_a), .b_in(w1_b),
    .in_valid(w1_valid), .in_ready(w1_ready), .sum_out(w1_sum),
    .sum_valid(w1_sv), .last(w1_last), .cout(w1_cout), .done_tick(w1_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full operation on the W-word DUT. Inputs change on negedges; outputs
  // are sampled on the negedge after each accepting posedge.
  task automatic run_op(input string name, input logic [NW-1:0] av, input logic [NW-1:0] bv,
                        input bit issue_start, input int stall_after, input int stall_len,
                        input int start_at, input bit b2b);
    logic [NW:0]  total;
    logic [N-1:0] exp_w;
    logic [2:0]   exp_f;
    total = {1'b0, av} + {1'b0, bv};
    if (issue_start) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready_after_start got %b exp 1", name, in_ready);
    end
    for (int i = 0; i < int'(W); i++) begin
      a_in     = av[i*N +: N];
      b_in     = bv[i*N +: N];
      in_valid = 1'b1;
      if (i == start_at) start = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
      exp_w = total[i*N +: N];
      exp_f = (i == int'(W) - 1) ? 3'b111 : 3'b100;
      checks++;
      if (sum_out !== exp_w) begin
        errors++;
        $display("FAIL %s sum_word%0d got %h exp %h", name, i, sum_out, exp_w);
      end
      checks++;
      if ({sum_valid, last, done_tick} !== exp_f) begin
        errors++;
        $display("FAIL %s flags_word%0d {valid,last,done} got %b exp %b", name, i,
                 {sum_valid, last, done_tick}, exp_f);
      end
      if (i == int'(W) - 1) begin
        checks++;
        if (cout !== total[NW]) begin
          errors++;
          $display("FAIL %s cout got %b exp %b", name, cout, total[NW]);
        end
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s in_ready_after_final got %b exp 0", name, in_ready);
        end
        if (b2b) start = 1'b1;
      end else if (i == stall_after) begin
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          checks++;
          if ({sum_valid, in_ready, sum_out} !== {1'b0, 1'b1, exp_w}) begin
            errors++;
            $display("FAIL %s stall%0d {valid,ready,sum} got %b_%b_%h exp 0_1_%h", name, s,
                     sum_valid, in_ready, sum_out, exp_w);
          end
        end
      end
    end
    if (!b2b) begin
      @(negedge clk);
      checks++;
      if ({sum_valid, done_tick, cout} !== {1'b0, 1'b0, total[NW]}) begin
        errors++;
        $display("FAIL %s post_op {valid,done,cout} got %b exp 00%b", name,
                 {sum_valid, done_tick, cout}, total[NW]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 0; in_valid = 0; a_in = '0; b_in = '0;
    w1_start = 0; w1_valid = 0; w1_a = '0; w1_b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({sum_out, sum_valid, last, cout, done_tick, in_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h_%b%b%b%b%b exp 0", sum_out, sum_valid, last, cout,
               done_tick, in_ready);
    end
    checks++;
    if ({w1_sum, w1_sv, w1_last, w1_cout, w1_done, w1_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_w1 got %h_%b%b%b%b%b exp 0", w1_sum, w1_sv, w1_last,
               w1_cout, w1_done, w1_ready);
    end
    reset = 1'b1;
  endtask

  task automatic test_idle_ignore();
    @(negedge clk);
    a_in = 4'hF; b_in = 4'hF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({sum_valid, in_ready} !== 2'b00) begin
      errors++;
      $display("FAIL idle_ignore {valid,ready} got %b exp 00", {sum_valid, in_ready});
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_in = 16'h1234 >> (i*N); b_in = 16'h4321 >> (i*N); in_valid = 1'b1;
      @(negedge clk);
    end
    checks++;
    if ({sum_valid, sum_out} !== {1'b1, 4'h5}) begin
      errors++;
      $display("FAIL reset_mid_pre got %b_%h exp 1_5", sum_valid, sum_out);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({sum_out, sum_valid, last, cout, done_tick, in_ready} !== '0) begin
      errors++;
      $display("FAIL reset_mid_async got %h_%b%b%b%b%b exp 0", sum_out, sum_valid, last, cout,
               done_tick, in_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({in_ready, sum_valid, done_tick} !== 3'b000) begin
        errors++;
        $display("FAIL reset_mid_after {ready,valid,done} got %b exp 000",
                 {in_ready, sum_valid, done_tick});
      end
    end
    in_valid = 1'b0;
    run_op("reset_mid_fresh", 16'h1234, 16'h4321, 1, -1, 0, -1, 0);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_first", 16'hFFFF, 16'h0001, 1, -1, 0, -1, 1);
    run_op("b2b_second", 16'h1234, 16'h4321, 0, -1, 0, -1, 0);
  endtask

  task automatic test_w1();
    logic [N:0] tot;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      w1_start = 1'b1;
      @(negedge clk);
      w1_start = 1'b0;
      if (k == 0) begin
        w1_a = 4'h9; w1_b = 4'h8;
      end else begin
        w1_a = N'($urandom); w1_b = N'($urandom);
      end
      tot = {1'b0, w1_a} + {1'b0, w1_b};
      w1_valid = 1'b1;
      @(negedge clk);
      w1_valid = 1'b0;
      checks++;
      if ({w1_sum, w1_sv, w1_last, w1_done, w1_cout, w1_ready} !==
          {tot[N-1:0], 3'b111, tot[N], 1'b0}) begin
        errors++;
        $display("FAIL w1_op%0d {sum,valid,last,done,cout,ready} got %h_%b%b%b%b%b exp %h_111%b0",
                 k, w1_sum, w1_sv, w1_last, w1_done, w1_cout, w1_ready, tot[N-1:0], tot[N]);
      end
    end
  endtask

  task automatic test_random();
    logic [NW-1:0] av, bv;
    for (int k = 0; k < 20; k++) begin
      av = NW'($urandom);
      bv = NW'($urandom);
      if (k == 0) begin av = '1; bv = '1; end
      run_op("random", av, bv, 1,
             ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, W - 2)) : -1,
             int'($urandom_range(1, 4)),
             ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, W - 1)) : -1, 0);
    end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    run_op("carry_ripple", 16'hFFFF, 16'h0001, 1, -1, 0, -1, 0);
    run_op("no_carry", 16'h1234, 16'h4321, 1, -1, 0, -1, 0);
    run_op("stall", 16'h1234, 16'h4321, 1, 1, 3, -1, 0);
    run_op("start_in_run", 16'hFFFF, 16'h0001, 1, -1, 0, 1, 0);
    test_reset_mid();
    test_back_to_back();
    test_w1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
